// File: rtl/mux_arb_n.sv
// N-channel registered mux/arbiter with a ready/valid output stage and forced-select mode.
// Define MUX_ARB_RR_EN for round-robin arbitration in mode 0; otherwise the lowest valid index wins.
module mux_arb_n #(
  parameter int N  = 6,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*W-1:0]  din,
  input  logic [N-1:0]    din_vld,
  output logic [N-1:0]    din_rdy,
  input  logic            mode,
  input  logic [SW-1:0]   s,
  output logic [W-1:0]    y,
  output logic            y_vld,
  input  logic            y_rdy,
  output logic [SW-1:0]   y_ch
);

  logic [N-1:0]  grant;
  logic [SW-1:0] sel;
  logic          s_ok;
  logic          out_free;
  logic          load;

  logic [W-1:0]  y_q, y_d;
  logic          y_vld_q, y_vld_d;
  logic [SW-1:0] y_ch_q, y_ch_d;

`ifdef MUX_ARB_RR_EN
  logic [SW-1:0] ptr_q, ptr_d;
  logic          found;
  int            k;
`endif

  assign s_ok = (32'(s) < N);

  always_comb begin
    grant = '0;
    sel   = '0;
`ifdef MUX_ARB_RR_EN
    found = 1'b0;
    k     = 0;
`endif
    if (mode) begin
      if (s_ok && din_vld[s]) begin
        grant[s] = 1'b1;
        sel      = s;
      end
    end else begin
`ifdef MUX_ARB_RR_EN
      // Search starts at the pointer and wraps; the first valid channel wins.
      for (int j = 0; j < N; j++) begin
        k = int'(ptr_q) + j;
        if (k >= N) k = k - N;
        if (!found && din_vld[k]) begin
          found    = 1'b1;
          grant[k] = 1'b1;
          sel      = SW'(k);
        end
      end
`else
      for (int i = N - 1; i >= 0; i--) begin
        if (din_vld[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          sel      = SW'(i);
        end
      end
`endif
    end
  end

  assign out_free = !y_vld_q || y_rdy;
  assign load     = out_free && (grant != '0) && !rst;
  assign din_rdy  = (out_free && !rst) ? grant : '0;

  always_comb begin
    y_d     = y_q;
    y_ch_d  = y_ch_q;
    y_vld_d = y_vld_q;
    if (load) begin
      y_d     = din[int'(sel)*W +: W];
      y_ch_d  = sel;
      y_vld_d = 1'b1;
    end else if (y_rdy) begin
      y_vld_d = 1'b0;
    end
  end

`ifdef MUX_ARB_RR_EN
  // Only arbitrated loads advance the pointer; forced selects leave it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (load && !mode) begin
      ptr_d = (int'(sel) == N - 1) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= '0;
      y_vld_q <= 1'b0;
      y_ch_q  <= '0;
    end else begin
      y_q     <= y_d;
      y_vld_q <= y_vld_d;
      y_ch_q  <= y_ch_d;
    end
  end

  assign y     = y_q;
  assign y_vld = y_vld_q;
  assign y_ch  = y_ch_q;

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed, table-driven bench for mux_arb_n (N=6, W=8); expectations follow MUX_ARB_RR_EN.
module tb_mux_arb_n;

  localparam int N  = 6;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] din;
  logic [N-1:0]   din_vld;
  logic [N-1:0]   din_rdy;
  logic           mode;
  logic [SW-1:0]  s;
  logic [W-1:0]   y;
  logic           y_vld;
  logic           y_rdy;
  logic [SW-1:0]  y_ch;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         mode;
    logic [2:0]   s;
    logic [5:0]   vld;
    logic         y_rdy;
    logic [5:0]   exp_rdy;
    logic         exp_vld;
    logic [7:0]   exp_y;
    logic [2:0]   exp_ch;
  } vec_t;

  vec_t vecs[$];

  mux_arb_n #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .mode(mode), .s(s), .y(y), .y_vld(y_vld), .y_rdy(y_rdy), .y_ch(y_ch)
  );

  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(logic m, logic [2:0] sv, logic [5:0] v, logic r,
                              logic [5:0] er, logic ev, logic [7:0] ey, logic [2:0] ec);
    vec_t t;
    t.mode = m; t.s = sv; t.vld = v; t.y_rdy = r;
    t.exp_rdy = er; t.exp_vld = ev; t.exp_y = ey; t.exp_ch = ec;
    return t;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(logic m, logic [2:0] sv, logic [5:0] v, logic r);
    mode = m; s = sv; din_vld = v; y_rdy = r;
  endtask

  task automatic check_y(string name, logic ev, logic [7:0] ey, logic [2:0] ec);
    check_output({name, "_vld"}, 32'(y_vld), 32'(ev));
    check_output({name, "_y"},   32'(y),     32'(ey));
    check_output({name, "_ch"},  32'(y_ch),  32'(ec));
  endtask

  initial begin
    int exp_seq[4];

    rst = 1'b1;
    for (int i = 0; i < N; i++) din[i*W +: W] = 8'h10 + 8'(i);
    apply_stimulus(1'b0, 3'd0, 6'h3F, 1'b1);

    // Held in reset across edges with every channel requesting.
    step();
    check_output("rst_din_rdy", 32'(din_rdy), 32'h0);
    step();
    check_y("rst", 1'b0, 8'h00, 3'd0);
    check_output("rst_din_rdy2", 32'(din_rdy), 32'h0);
    rst = 1'b0;

`ifdef MUX_ARB_RR_EN
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000001, 1, 8'h10, 0));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000010, 1, 8'h11, 1));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000100, 1, 8'h12, 2));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b001000, 1, 8'h13, 3));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b010000, 1, 8'h14, 4));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b100000, 1, 8'h15, 5));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000001, 1, 8'h10, 0));
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b000010, 1, 8'h11, 1));
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b000100, 1, 8'h12, 2));
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b100000, 1, 8'h15, 5));
    vecs.push_back(mk(1, 2, 6'h3F, 1, 6'b000100, 1, 8'h12, 2));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000001, 1, 8'h10, 0));
    vecs.push_back(mk(1, 7, 6'h3F, 1, 6'b000000, 0, 8'h10, 0));
`else
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b000010, 1, 8'h11, 1));
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b000010, 1, 8'h11, 1));
    vecs.push_back(mk(0, 0, 6'b100110, 1, 6'b000010, 1, 8'h11, 1));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000001, 1, 8'h10, 0));
    vecs.push_back(mk(0, 0, 6'h00, 1, 6'b000000, 0, 8'h10, 0));
    vecs.push_back(mk(1, 3, 6'h3F, 1, 6'b001000, 1, 8'h13, 3));
    vecs.push_back(mk(1, 7, 6'h3F, 1, 6'b000000, 0, 8'h13, 3));
    vecs.push_back(mk(1, 6, 6'h3F, 1, 6'b000000, 0, 8'h13, 3));
    vecs.push_back(mk(0, 0, 6'b110000, 0, 6'b010000, 1, 8'h14, 4));
    vecs.push_back(mk(0, 0, 6'h3F, 0, 6'b000000, 1, 8'h14, 4));
    vecs.push_back(mk(1, 5, 6'h3F, 0, 6'b000000, 1, 8'h14, 4));
    vecs.push_back(mk(0, 0, 6'h3F, 1, 6'b000001, 1, 8'h10, 0));
`endif

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].mode, vecs[i].s, vecs[i].vld, vecs[i].y_rdy);
      #1;
      check_output($sformatf("vec%0d_din_rdy", i), 32'(din_rdy), 32'(vecs[i].exp_rdy));
      step();
      check_y($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_y, vecs[i].exp_ch);
    end

    // Backpressure: output held for three cycles, then replaced without a gap.
    rst = 1'b1; #1; rst = 1'b0;
    apply_stimulus(1'b0, 3'd0, 6'h3F, 1'b1);
    #1;
    check_output("bp_first_rdy", 32'(din_rdy), 32'h01);
    step();
    check_y("bp_first", 1'b1, 8'h10, 3'd0);
    y_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_output($sformatf("bp_hold%0d_rdy", c), 32'(din_rdy), 32'h0);
      step();
      check_y($sformatf("bp_hold%0d", c), 1'b1, 8'h10, 3'd0);
    end
    apply_stimulus(1'b0, 3'd0, 6'h3E, 1'b1);
    #1;
    check_output("bp_release_rdy", 32'(din_rdy), 32'h02);
    step();
    check_y("bp_release", 1'b1, 8'h11, 3'd1);

    // Asynchronous reset mid-cycle while a word is held.
    apply_stimulus(1'b0, 3'd0, 6'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_y("arst", 1'b0, 8'h00, 3'd0);
    check_output("arst_din_rdy", 32'(din_rdy), 32'h0);
    apply_stimulus(1'b0, 3'd0, 6'h3F, 1'b1);
    step();
    check_y("arst_edge", 1'b0, 8'h00, 3'd0);
    rst = 1'b0;
    #1;
    check_output("arst_after_rdy", 32'(din_rdy), 32'h01);
    step();
    check_y("arst_after", 1'b1, 8'h10, 3'd0);

    // Forced select of channel 4, then an out-of-range index.
    din[4*W +: W] = 8'hA5;
    apply_stimulus(1'b1, 3'd4, 6'b010000, 1'b1);
    #1;
    check_output("force4_rdy", 32'(din_rdy), 32'h10);
    step();
    check_y("force4", 1'b1, 8'hA5, 3'd4);
    s = 3'd7;
    #1;
    check_output("force7_rdy", 32'(din_rdy), 32'h0);
    step();
    check_y("force7", 1'b0, 8'hA5, 3'd4);
    din[4*W +: W] = 8'h14;

    // Load channel 4 (pointer moves to 5 in round-robin), then alternate 5 and 0.
    apply_stimulus(1'b0, 3'd0, 6'b010000, 1'b1);
    step();
    check_y("pre_wrap", 1'b1, 8'h14, 3'd4);
`ifdef MUX_ARB_RR_EN
    exp_seq = '{5, 0, 5, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    din_vld = 6'b100001;
    for (int c = 0; c < 4; c++) begin
      step();
      check_y($sformatf("wrap%0d", c), 1'b1, 8'h10 + 8'(exp_seq[c]), 3'(exp_seq[c]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_arb_n.md
MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 The module SHALL have parameter N, default 6, meaning number of input channels (2..16).
REQ-002 The module SHALL have parameter W, default 8, meaning data width per channel.
REQ-003 The module SHALL have parameter SW, default $clog2(N), meaning width of channel-index signals.
REQ-004 The module SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The module SHALL have port din  input  N*W  channel data, channel i at bits [i*W +: W].
REQ-007 The module SHALL have port din_vld  input  N  per-channel data valid.
REQ-008 The module SHALL have port din_rdy  output  N  per-channel accept strobe.
REQ-009 The module SHALL have port mode  input  1  selection mode: 0 = arbitrate, 1 = forced select.
REQ-010 The module SHALL have port s  input  SW  forced channel index, used when mode=1.
REQ-011 The module SHALL have port y  output  W  registered output data.
REQ-012 The module SHALL have port y_vld  output  1  output data valid.
REQ-013 The module SHALL have port y_rdy  input  1  downstream ready.
REQ-014 The module SHALL have port y_ch  output  SW  source channel of the current y.

Function
REQ-015 load SHALL equal (!y_vld | y_rdy) & (grant != 0); at most one grant bit SHALL be set per cycle.
REQ-016 din_rdy SHALL equal grant gated by (!y_vld | y_rdy), combinationally, with no dependence on din_rdy itself.
REQ-017 On load, y, y_ch and y_vld=1 SHALL register on the next rising edge; input-to-output latency SHALL be 1 cycle, with throughput of 1 word/cycle.
REQ-018 With y_vld=1 and y_rdy=0, y, y_ch and y_vld SHALL hold stable and all din_rdy SHALL be 0.
REQ-019 With y_vld=1, y_rdy=1 and no grant, y_vld SHALL clear on the next edge; y SHALL hold its last value.
REQ-020 With y_vld=1, y_rdy=1 and a grant in the same cycle, the output SHALL be replaced with no bubble cycle.
REQ-021 In mode=1, grant[s] SHALL be set iff din_vld[s]=1 and s<N; for s>=N the module SHALL grant nothing and din_rdy SHALL be 0.
REQ-022 In mode=0, the grant SHALL go to the first valid channel found by the arbitration rule (see Configuration).
REQ-023 A change of mode or s SHALL affect only the next grant decision; a held output SHALL be unaffected.
REQ-024 Round-robin pointer ptr (SW bits) SHALL update to (k+1) mod N on each mode=0 load from channel k; at k=N-1 it SHALL wrap to 0.
REQ-025 Mode=1 loads SHALL leave ptr unchanged.

Reset
REQ-026 Asserting rst SHALL immediately clear y=0, y_vld=0, y_ch=0 and ptr=0.
REQ-027 While rst is high, din_rdy SHALL be all 0.
REQ-028 A word held at reset assertion SHALL be discarded and never presented again.
REQ-029 The first load SHALL occur no earlier than the first rising edge after rst deasserts.

Configuration
REQ-030 With macro MUX_ARB_RR_EN defined, mode=0 SHALL use round-robin search starting at ptr, then ptr+1, and so on, wrapping modulo N.
REQ-031 Without MUX_ARB_RR_EN, mode=0 SHALL use fixed priority, lowest valid index wins; ptr SHALL not exist; REQ-024/025 SHALL not apply.

Verification
REQ-032 N=6, W=8, RR_EN on: all din_vld=6'h3F, din[i]=8'h10+i, y_rdy=1 -> y sequence 10,11,12,13,14,15,10 on consecutive cycles, y_ch 0..5,0.
REQ-033 RR_EN off: din_vld=6'b100110, y_rdy=1 -> y_ch=1 every cycle, din_rdy=6'b000010.
REQ-034 mode=1, s=4, din_vld[4]=1, din[4]=8'hA5 -> y=A5, y_ch=4 one cycle later; then s=7 -> din_rdy=0, y_vld drops next cycle.
REQ-035 Backpressure: y_vld=1, y_rdy=0 for 3 cycles with all channels valid -> y stable, din_rdy=0; on y_rdy=1, the next word loads the following cycle with no gap.
REQ-036 Async reset: assert rst mid-cycle while y_vld=1 -> y_vld=0, y=0 before the next edge; after release, the RR grant starts at channel 0.
REQ-037 Wrap: RR_EN on, only din_vld[5] and din_vld[0] set, ptr=5 -> grants 5,0,5,0 on successive loads.
